// File: rtl/dma_copy_engine.sv
// dma_copy_engine
// ---------------------------------------------------------------------------
// Word-copy DMA master for the data-memory port of the single-cycle MIPS core.
// It copies len_words 32-bit words from src_addr to dst_addr in ascending
// order. It uses the same address/wdata/read/write signals as the CPU and
// takes the port through a bus_req/bus_gnt handshake with the stall logic.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   start         transfer request, sampled only while idle
//   src_addr      byte address of the first source word
//   dst_addr      byte address of the first destination word
//   len_words     number of words to copy
//   bus_req       DMA wants the data-memory port
//   bus_gnt       CPU has released the port
//   mem_addr      byte address to data memory
//   mem_wdata     write data to data memory
//   mem_rdata     combinational read data from data memory
//   mem_read      read enable
//   mem_write     write enable (memory writes on posedge)
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
//   err           high with done when the transfer was rejected
//   words_done    words written so far in the current or last transfer
//   dbg_state     current FSM state encoding, for observation only
//
// Handshake: bus_req is held from REQ through the last WR. A memory access
// counts only in a cycle where bus_gnt is also high. When bus_gnt drops
// during RD, the read is discarded. When bus_gnt drops during WR, the write
// is suppressed. In both cases the engine falls back to REQ, and the same
// word is read and written again after the grant returns.
//
// A rejected transfer (misaligned or out of bounds) and a zero-length
// transfer never raise bus_req. Copies are strictly ascending. When the
// destination overlaps the source above it, later source words are
// overwritten before they are read; that result is intended.
// ---------------------------------------------------------------------------
module dma_copy_engine #(
  parameter int MEM_BYTES = 1024,
  parameter int LEN_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_REQ   = 3'd2,
    S_RD    = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [33:0] MEM_LIMIT = 34'(MEM_BYTES);

  state_t           state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [LEN_W-1:0] len_r;
  logic             err_r;
  logic             mem_write_r;

  // End addresses are computed at 34 bits so that a large pointer plus
  // length cannot wrap and slip past the bounds check.
  logic [33:0] src_end;
  logic [33:0] dst_end;
  logic        chk_err;
  logic        last_word;
  logic [31:0] src_nxt;
  logic [31:0] dst_nxt;

  assign src_end   = {2'b00, src_ptr} + {{(32-LEN_W){1'b0}}, len_r, 2'b00};
  assign dst_end   = {2'b00, dst_ptr} + {{(32-LEN_W){1'b0}}, len_r, 2'b00};
  assign chk_err   = (src_ptr[1:0] != 2'b00) || (dst_ptr[1:0] != 2'b00) ||
                     (src_end > MEM_LIMIT) || (dst_end > MEM_LIMIT);
  assign last_word = ((words_done + LEN_W'(1)) == len_r);
  assign src_nxt   = src_ptr + 32'd4;
  assign dst_nxt   = dst_ptr + 32'd4;

  // The registered write strobe is qualified with the live grant and reset,
  // so that a grant drop or a reset in mid-WR blocks the write in that
  // same cycle.
  assign mem_write = mem_write_r & bus_gnt & ~rst;
  assign dbg_state = state;

  // The outputs are registered. Each transition loads the values that the
  // destination state presents in its own cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      len_r       <= '0;
      err_r       <= 1'b0;
      words_done  <= '0;
      bus_req     <= 1'b0;
      mem_read    <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      bus_req     <= 1'b0;
      mem_read    <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b1;

      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            src_ptr    <= src_addr;
            dst_ptr    <= dst_addr;
            len_r      <= len_words;
            words_done <= '0;
            busy       <= 1'b1;
            state      <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (chk_err) begin
            err_r <= 1'b1;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_DONE;
          end else if (len_r == '0) begin
            err_r <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            err_r   <= 1'b0;
            bus_req <= 1'b1;
            state   <= S_REQ;
          end
        end

        S_REQ: begin
          bus_req <= 1'b1;
          if (bus_gnt) begin
            mem_read <= 1'b1;
            mem_addr <= src_ptr;
            state    <= S_RD;
          end
        end

        S_RD: begin
          bus_req <= 1'b1;
          if (bus_gnt) begin
            // The wdata register doubles as the word buffer for the WR cycle.
            mem_wdata   <= mem_rdata;
            mem_write_r <= 1'b1;
            mem_addr    <= dst_ptr;
            state       <= S_WR;
          end else begin
            state <= S_REQ;
          end
        end

        S_WR: begin
          if (bus_gnt) begin
            src_ptr    <= src_nxt;
            dst_ptr    <= dst_nxt;
            words_done <= words_done + LEN_W'(1);
            if (last_word) begin
              done  <= 1'b1;
              err   <= err_r;
              state <= S_DONE;
            end else begin
              bus_req  <= 1'b1;
              mem_read <= 1'b1;
              mem_addr <= src_nxt;
              state    <= S_RD;
            end
          end else begin
            bus_req <= 1'b1;
            state   <= S_REQ;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
